// File: rtl/data_ram_resp.sv
// data_ram_resp: responder for the CPU data-memory port.
// Word-organised data store with big-endian byte-lane writes
// (sel_i[3] = bits 31:24 = lowest byte address), plus a 16-byte register
// window at MMIO_BASE: CYCLE (RO), TOHOST (RW), SCRATCH (RW), reserved.
// Reads are combinational and writes take effect on the next rising edge.
// No wait states and no handshake.
// Optional build macro: DATA_RAM_BOUND_CHECK_EN. When it is defined,
// out-of-range RAM accesses are suppressed and flagged on err_o.
// When it is undefined, addresses alias modulo DEPTH and err_o stays 0.
module data_ram_resp #(
  parameter int          DEPTH     = 4096,
  parameter int          AW        = 12,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,        // active-low, asynchronous assert
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        done_o,
  output logic [31:0] tohost_o,
  output logic        err_o
);

  localparam logic [1:0] OFF_CYCLE   = 2'd0;
  localparam logic [1:0] OFF_TOHOST  = 2'd1;
  localparam logic [1:0] OFF_SCRATCH = 2'd2;

  // Storage. Contents are deliberately not reset.
  logic [31:0] mem [0:DEPTH-1];

  logic [31:0] cycle_reg;
  logic [31:0] tohost_reg;
  logic [31:0] scratch_reg;
  logic        done_reg;
  logic        err_reg;

  logic          mmio_hit;
  logic          ram_hit;
  logic          out_of_range;
  logic          ram_ok;
  logic          mmio_wr;
  logic [1:0]    reg_off;
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_rd_word;
  logic [31:0]   ram_wr_next;
  logic [31:0]   tohost_next;
  logic [31:0]   scratch_next;

  // The byte offset within a word has no meaning for a word-organised store.
  logic unused_byte_offset;
  assign unused_byte_offset = ^addr_i[1:0];

  assign mmio_hit = ce_i && (addr_i[31:4] == MMIO_BASE[31:4]);
  assign ram_hit  = ce_i && !mmio_hit;
  assign reg_off  = addr_i[3:2];
  assign word_idx = addr_i[AW+1:2];
  assign mmio_wr  = mmio_hit && we_i;

`ifdef DATA_RAM_BOUND_CHECK_EN
  // Any set bit above the word index means the access is outside the store.
  assign out_of_range = ram_hit && (addr_i[31:AW+2] != '0);
`else
  // Upper bits are ignored, so addresses alias modulo DEPTH.
  assign out_of_range = 1'b0;
`endif

  assign ram_ok      = ram_hit && !out_of_range;
  assign ram_rd_word = mem[word_idx];

  // Per-lane merge of the write data with the current contents.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
      assign ram_wr_next[8*gi +: 8]  = sel_i[gi] ? data_i[8*gi +: 8] : ram_rd_word[8*gi +: 8];
      assign tohost_next[8*gi +: 8]  = sel_i[gi] ? data_i[8*gi +: 8] : tohost_reg[8*gi +: 8];
      assign scratch_next[8*gi +: 8] = sel_i[gi] ? data_i[8*gi +: 8] : scratch_reg[8*gi +: 8];
    end
  endgenerate

  // RAM write: the merged word is written back, so unselected lanes keep their value.
  always_ff @(posedge clk) begin
    if (ram_ok && we_i) begin
      mem[word_idx] <= ram_wr_next;
    end
  end

  // Register window state, cycle counter and the registered error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_reg   <= 32'd0;
      tohost_reg  <= 32'd0;
      scratch_reg <= 32'd0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
      err_reg   <= out_of_range;
      if (mmio_wr && (reg_off == OFF_TOHOST)) begin
        tohost_reg <= tohost_next;
        if (tohost_next != 32'd0) begin
          done_reg <= 1'b1;
        end
      end
      if (mmio_wr && (reg_off == OFF_SCRATCH)) begin
        scratch_reg <= scratch_next;
      end
    end
  end

  // Zero-latency read mux. sel_i does not mask reads.
  always_comb begin
    data_o = 32'd0;
    if (ce_i && !we_i) begin
      if (mmio_hit) begin
        case (reg_off)
          OFF_CYCLE:   data_o = cycle_reg;
          OFF_TOHOST:  data_o = tohost_reg;
          OFF_SCRATCH: data_o = scratch_reg;
          default:     data_o = 32'd0;
        endcase
      end else if (ram_ok) begin
        data_o = ram_rd_word;
      end
    end
  end

  assign done_o   = done_reg;
  assign tohost_o = tohost_reg;
  assign err_o    = err_reg;

endmodule
